// File: rtl/vga_reg_display.sv
// rtl/vga_reg_display.sv - VGA renderer showing a register bank as 0/1 glyphs; optional change highlight via VGA_REG_HIGHLIGHT_EN
module vga_reg_display #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 48,
    parameter int H_SYNC    = 112,
    parameter int H_BP      = 248,
    parameter int V_ACTIVE  = 1024,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 38,
    parameter int ROWS      = 32,
    parameter int WORD_W    = 32,
    parameter int X0        = 64,
    parameter int Y0        = 0,
    parameter int HL_FRAMES = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_addr,
    input  logic [WORD_W-1:0]       wr_data,
    output logic                    vga_hsync,
    output logic                    vga_vsync,
    output logic                    vga_de,
    output logic [3:0]              vga_r,
    output logic [3:0]              vga_g,
    output logic [3:0]              vga_b,
    output logic                    frame_start
);
    localparam int ADDR_W  = $clog2(ROWS);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HX_W    = $clog2(H_TOTAL);
    localparam int VY_W    = $clog2(V_TOTAL);
    localparam int COL_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [HX_W-1:0] SX_LAST = HX_W'(H_TOTAL - 1);
    localparam logic [HX_W-1:0] HS_BEG  = HX_W'(H_ACTIVE + H_FP);
    localparam logic [HX_W-1:0] HS_END  = HX_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HX_W-1:0] HA      = HX_W'(H_ACTIVE);
    localparam logic [HX_W-1:0] FX0     = HX_W'(X0);
    localparam logic [HX_W-1:0] FW      = HX_W'(8 * WORD_W);
    localparam logic [VY_W-1:0] SY_LAST = VY_W'(V_TOTAL - 1);
    localparam logic [VY_W-1:0] VS_BEG  = VY_W'(V_ACTIVE + V_FP);
    localparam logic [VY_W-1:0] VS_END  = VY_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VY_W-1:0] VA      = VY_W'(V_ACTIVE);
    localparam logic [VY_W-1:0] FY0     = VY_W'(Y0);
    localparam logic [VY_W-1:0] FH      = VY_W'(16 * ROWS);

    localparam logic [11:0] C_BG = 12'h537;
    localparam logic [11:0] C_ON = 12'hFFF;
    localparam logic [11:0] C_HL = 12'hFF0;

    logic [HX_W-1:0]   sx;
    logic [VY_W-1:0]   sy;
    logic [WORD_W-1:0] mem [ROWS];

    // Stage 0: free-running pixel/line counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sx <= '0;
            sy <= '0;
        end else if (sx == SX_LAST) begin
            sx <= '0;
            sy <= (sy == SY_LAST) ? '0 : sy + 1'b1;
        end else begin
            sx <= sx + 1'b1;
        end
    end

    // Offsets wrap to large values left of / above the origin, so one
    // unsigned compare per axis decides field membership.
    logic [HX_W-1:0]   dx;
    logic [VY_W-1:0]   dy;
    logic              in_field;
    logic [ADDR_W-1:0] row_idx;
    logic              hs0, vs0, de0, fs0, wr_ok, row_hl;

    assign dx       = sx - FX0;
    assign dy       = sy - FY0;
    assign in_field = (dx < FW) && (dy < FH);
    assign row_idx  = (dy < FH) ? dy[4 +: ADDR_W] : '0;
    assign hs0      = !((sx >= HS_BEG) && (sx < HS_END));
    assign vs0      = !((sy >= VS_BEG) && (sy < VS_END));
    assign de0      = (sx < HA) && (sy < VA);
    assign fs0      = (sx == '0) && (sy == '0);
    assign wr_ok    = wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(ROWS));

    // Register bank write port; stage-1 reads see the pre-write contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) mem[r] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef VGA_REG_HIGHLIGHT_EN
    localparam int HL_W = $clog2(HL_FRAMES + 1);
    logic [HL_W-1:0] hl_cnt [ROWS];

    // Per-row highlight timers: a write reloads, each frame start counts down
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) hl_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (wr_ok && (wr_addr == ADDR_W'(r)))
                    hl_cnt[r] <= HL_W'(HL_FRAMES);
                else if (fs0 && (hl_cnt[r] != '0))
                    hl_cnt[r] <= hl_cnt[r] - 1'b1;
            end
        end
    end

    assign row_hl = (hl_cnt[row_idx] != '0);
`else
    assign row_hl = 1'b0;
`endif

    logic [WORD_W-1:0] s1_word;
    logic [3:0]        s1_gy;
    logic [2:0]        s1_gx;
    logic [COL_W-1:0]  s1_col;
    logic              s1_field, s1_hl, s1_hs, s1_vs, s1_de, s1_fs;

    // Stage 1: fetch the row word and glyph coordinates, delay syncs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_word  <= '0;
            s1_gy    <= '0;
            s1_gx    <= '0;
            s1_col   <= '0;
            s1_field <= 1'b0;
            s1_hl    <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_de    <= 1'b0;
            s1_fs    <= 1'b0;
        end else begin
            s1_word  <= mem[row_idx];
            s1_gy    <= dy[3:0];
            s1_gx    <= dx[2:0];
            s1_col   <= dx[3 +: COL_W];
            s1_field <= in_field;
            s1_hl    <= row_hl;
            s1_hs    <= hs0;
            s1_vs    <= vs0;
            s1_de    <= de0;
            s1_fs    <= fs0;
        end
    end

    function automatic logic [7:0] glyph_line(input logic one, input logic [3:0] gy);
        if (one)
            return ((gy >= 4'd2) && (gy <= 4'd13)) ? 8'b00011000 : 8'b00000000;
        else if ((gy == 4'd2) || (gy == 4'd13))
            return 8'b01111110;
        else if ((gy >= 4'd3) && (gy <= 4'd12))
            return 8'b01000010;
        else
            return 8'b00000000;
    endfunction

    logic [COL_W-1:0] bit_idx;
    logic [7:0]       line_bits;
    logic             pix_on;
    logic [11:0]      rgb_next, rgb_q;

    assign bit_idx   = COL_W'(WORD_W - 1) - s1_col;
    assign line_bits = glyph_line(s1_word[bit_idx], s1_gy);
    assign pix_on    = line_bits[3'd7 - s1_gx];

    // Colour select: blanking, then background, then glyph ink
    always_comb begin
        rgb_next = 12'h000;
        if (!s1_de)
            rgb_next = 12'h000;
        else if (!s1_field)
            rgb_next = C_BG;
        else if (pix_on)
            rgb_next = s1_hl ? C_HL : C_ON;
        else
            rgb_next = C_BG;
    end

    // Stage 2: register colour alongside the twice-delayed syncs
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q       <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb_q       <= rgb_next;
            vga_hsync   <= s1_hs;
            vga_vsync   <= s1_vs;
            vga_de      <= s1_de;
            frame_start <= s1_fs;
        end
    end

    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];
endmodule

// File: tb/tb_vga_reg_display.sv
// tb/tb_vga_reg_display.sv - directed-vector bench for vga_reg_display on a reduced timing
module tb_vga_reg_display;
    localparam int H_TOTAL = 144;   // 128 + 4 + 8 + 4
    localparam int V_TOTAL = 52;    // 48 + 1 + 2 + 1
    localparam int FRAME   = 7488;  // 144 * 52

    localparam logic [11:0] BG    = 12'h537;
    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] BLACK = 12'h000;
`ifdef VGA_REG_HIGHLIGHT_EN
    localparam logic [11:0] LIT_HL = 12'hFF0;
`else
    localparam logic [11:0] LIT_HL = 12'hFFF;
`endif

    logic       clk, rst, wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       vga_hsync, vga_vsync, vga_de, frame_start;
    logic [3:0] vga_r, vga_g, vga_b;
    logic [11:0] rgb;
    int cyc;
    int n_vec = 0;
    int n_bad = 0;

    vga_reg_display #(
        .H_ACTIVE(128), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .ROWS(3), .WORD_W(8), .X0(64), .Y0(0), .HL_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
    );

    assign rgb = {vga_r, vga_g, vga_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int at(input int f, input int x, input int y);
        return 2 + f * FRAME + y * H_TOTAL + x;
    endfunction

    task automatic wait_cyc(input int t);
        if (cyc > t) chk("schedule_late", cyc, t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic px(input string tag, input int f, input int x, input int y,
                      input logic [11:0] exp_rgb, input logic exp_de);
        wait_cyc(at(f, x, y));
        chk({tag, ".rgb"}, rgb, exp_rgb);
        chk({tag, ".de"}, vga_de, exp_de);
    endtask

    task automatic wr_fetch(input int f, input int x, input int y,
                            input logic [1:0] addr, input logic [7:0] data);
        wait_cyc(at(f, x, y) - 2);
        wr_en = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wait_cyc(at(f, x, y) - 1);
        wr_en = 1'b0;
    endtask

    initial begin
        int hs_f[2];
        int vs_f[2];
        int fs_c[3];
        int hs_r, vs_r, nh, nv, nf;
        logic hs_p, vs_p;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", vga_hsync, 1);
        chk("rst_vsync", vga_vsync, 1);
        chk("rst_de", vga_de, 0);
        chk("rst_rgb", rgb, BLACK);
        chk("rst_fs", frame_start, 0);
        rst = 1'b0;

        wait_cyc(1);
        chk("pre_fs", frame_start, 0);
        wait_cyc(2);
        chk("first_fs", frame_start, 1);
        chk("first_de", vga_de, 1);
        chk("first_rgb", rgb, BG);

        hs_f = '{0, 0}; vs_f = '{0, 0}; fs_c = '{2, 0, 0};
        hs_r = 0; vs_r = 0; nh = 0; nv = 0; nf = 1;
        hs_p = vga_hsync; vs_p = vga_vsync;
        while (cyc < 2 + 2 * FRAME + 2) begin
            @(posedge clk);
            #1;
            if (hs_p && !vga_hsync && nh < 2) begin hs_f[nh] = cyc; nh++; end
            if (!hs_p && vga_hsync && nh == 1 && hs_r == 0) hs_r = cyc;
            if (vs_p && !vga_vsync && nv < 2) begin vs_f[nv] = cyc; nv++; end
            if (!vs_p && vga_vsync && nv == 1 && vs_r == 0) vs_r = cyc;
            if (frame_start && nf < 3) begin fs_c[nf] = cyc; nf++; end
            hs_p = vga_hsync;
            vs_p = vga_vsync;
        end
        chk("hs_first_fall", hs_f[0], 134);
        chk("hs_width", hs_r - hs_f[0], 8);
        chk("hs_period", hs_f[1] - hs_f[0], 144);
        chk("vs_first_fall", vs_f[0], 7058);
        chk("vs_width", vs_r - vs_f[0], 288);
        chk("vs_period", vs_f[1] - vs_f[0], 7488);
        chk("fs_period0", fs_c[1] - fs_c[0], 7488);
        chk("fs_period1", fs_c[2] - fs_c[1], 7488);

        wr_fetch(2, 10, 0, 2'd0, 8'h80);
        wr_fetch(2, 20, 0, 2'd3, 8'hFF);

        px("blank_row", 3, 64, 0, BG, 1);
        px("last_col_on", 3, 126, 2, LIT_HL, 1);
        px("last_col_off", 3, 127, 2, BG, 1);
        px("one_glyph", 3, 67, 5, LIT_HL, 1);
        px("zero_glyph", 3, 73, 5, LIT_HL, 1);
        px("zero_gap", 3, 75, 5, BG, 1);
        px("left_bg", 3, 10, 10, BG, 1);
        px("h_blank", 3, 128, 10, BLACK, 0);
        px("row1_intact", 3, 65, 21, WHITE, 1);
        wr_fetch(3, 67, 37, 2'd2, 8'h80);
        px("rdw_old", 3, 67, 37, BG, 1);
        px("rdw_new", 3, 68, 37, LIT_HL, 1);
        px("v_blank", 3, 10, 48, BLACK, 0);

        wait_cyc(at(4, 70, 5));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_hsync", vga_hsync, 1);
        chk("mid_rst_vsync", vga_vsync, 1);
        chk("mid_rst_de", vga_de, 0);
        chk("mid_rst_rgb", rgb, BLACK);
        chk("mid_rst_fs", frame_start, 0);
        rst = 1'b0;
        wait_cyc(1);
        chk("post_rst1_fs", frame_start, 0);
        chk("post_rst1_de", vga_de, 0);
        chk("post_rst1_hs", vga_hsync, 1);
        wait_cyc(2);
        chk("post_rst2_fs", frame_start, 1);
        chk("post_rst2_de", vga_de, 1);
        chk("post_rst2_rgb", rgb, BG);
        px("rst_cleared_row0", 0, 67, 5, BG, 1);
        px("rst_cleared_hl", 0, 73, 5, WHITE, 1);

`ifdef VGA_REG_HIGHLIGHT_EN
        wr_fetch(0, 0, 50, 2'd1, 8'h80);
        px("hl_f1", 1, 67, 21, 12'hFF0, 1);
        wr_fetch(1, 0, 50, 2'd1, 8'h80);
        px("hl_extend", 2, 67, 21, 12'hFF0, 1);
        wr_fetch(3, 0, 0, 2'd1, 8'h80);
        px("hl_load_wins", 3, 67, 21, 12'hFF0, 1);
        px("hl_f4", 4, 67, 21, 12'hFF0, 1);
        px("hl_expired", 5, 67, 21, WHITE, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_reg_display.md
# vga_reg_display

Parametrised VGA renderer that displays a bank of `ROWS` registers of `WORD_W` bits as a grid of 8x16-pixel '0'/'1' glyphs. It has an internal timing generator, a write port so a debug source (UART receiver, CPU register snoop) can update any row at any time, and a 2-stage pixel pipeline with sync signals aligned to the colour outputs. It is the generalised successor to the fixed 1280x1024 bit-dump display: timing, geometry and row count are parameters, and it adds optional change highlighting.

## Interface
- `H_ACTIVE` 1280, `H_FP` 48, `H_SYNC` 112, `H_BP` 248: horizontal timing in pixels; H_TOTAL = sum = 1688.
- `V_ACTIVE` 1024, `V_FP` 1, `V_SYNC` 3, `V_BP` 38: vertical timing in lines; V_TOTAL = 1066.
- `ROWS` 32: number of displayed registers; ADDR_W = $clog2(ROWS).
- `WORD_W` 32: bits per register.
- `X0` 64, `Y0` 0: pixel origin of the glyph field.
- `HL_FRAMES` 60: highlight duration in frames (only with highlight feature).
- `clk` in 1: pixel clock.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: write strobe.
- `wr_addr` in ADDR_W: row to write; values >= ROWS are ignored.
- `wr_data` in WORD_W: row data.
- `vga_hsync`, `vga_vsync` out 1: syncs, negative polarity.
- `vga_de` out 1: active-video flag.
- `vga_r`, `vga_g`, `vga_b` out 4 each: colour.
- `frame_start` out 1: one-cycle pulse coincident with output pixel (0,0).

## Operation
- Stage 0 holds counters `sx` and `sy`. `sx` wraps from H_TOTAL-1 to 0. `sy` increments on each `sx` wrap and wraps from V_TOTAL-1 to 0.
- Sync: hsync is low when H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC. vsync is low when V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC. de = sx < H_ACTIVE and sy < V_ACTIVE.
- Field: X0 <= sx < X0+8*WORD_W and Y0 <= sy < Y0+16*ROWS.
  - row = (sy-Y0)/16, gy = (sy-Y0)%16, col = (sx-X0)/8, gx = (sx-X0)%8.
  - The displayed bit is WORD_W-1-col, so the MSB is leftmost.
- Glyph bitmaps (bit 7 is the leftmost pixel):
  - '0': rows 2 and 13 = 01111110; rows 3–12 = 01000010; all other rows 0.
  - '1': rows 2–13 = 00011000; all other rows 0.
- Stage 1 registers mem[row], gy, gx, col, the field flag and the syncs. Stage 2 registers the colour and the delayed syncs.
- Colour priority:
  - !de gives 000.
  - Outside the field gives background 537.
  - Glyph pixel on gives FFF, or FF0 when the row is highlighted.
  - Glyph pixel off gives 537.
- Register bank: `ROWS` x `WORD_W` flops, reset to 0. A write takes effect at the clock edge with `wr_en`.
- Read-during-write: a stage-1 read of the row being written in the same cycle returns the old value.

## Timing
- Pipeline latency: 2 clocks from stage-0 counters to all outputs. hsync, vsync, de, rgb and frame_start stay mutually aligned.
- Reset values: sx = sy = 0; vga_hsync = vga_vsync = 1; vga_de = 0; rgb = 000; frame_start = 0; all rows 0; all highlight counters 0.
- After reset is released, the first valid pixel (0,0) appears 2 cycles later with frame_start = 1.
- Line period is exactly H_TOTAL clocks; frame period is exactly H_TOTAL*V_TOTAL clocks.
- Reset asserted mid-frame clears the pipeline on the next edge. No partial sync pulse survives.
- A write is visible on the first pixel fetched at least 1 cycle after the write edge. Mid-frame writes may tear one frame; this is accepted.

## Configuration
- `VGA_REG_HIGHLIGHT_EN` defined:
  - Each row has a counter of width $clog2(HL_FRAMES+1).
  - A valid write loads HL_FRAMES into that row's counter.
  - On the stage-0 cycle at (0,0), every nonzero counter decrements.
  - If a write and a decrement hit the same row in the same cycle, the load wins.
  - A row is highlighted while its counter is nonzero.
- Not defined: no counters exist and glyphs are always FFF.

## Test plan
- Reset release, free run 2 frames:
  - Measure hsync low width 112 and period 1688, vsync low width 3 lines and period 1066 lines.
  - Check frame_start pulses every 1799408 clocks.
- Write row 0 = 0x80000000, then check frame pixels:
  - (67,5) = FFF, '1' column 3.
  - (73,5) = FFF, '0' column 1.
  - (75,5) = 537.
  - (64,0) = 537, glyph row 0 is blank.
- Blanking: pixel (1280,10) and pixel (10,1024) = 000 with de = 0; pixel (10,10) = 537 with de = 1.
- Read-during-write: write row 3 on the exact cycle stage 1 fetches row 3 → old data is displayed for that pixel, new data from the next fetch. Also write wr_addr = ROWS with ROWS < 2^ADDR_W → no change.
- With `VGA_REG_HIGHLIGHT_EN`: write row 5 → its lit pixels are FF0 for 60 frames, then FFF. Rewrite it at frame 30 → FF0 extends to frame 90. Write it on the decrement cycle → counter = 60.
- Assert rst for 1 cycle mid-line (sx = 700) → 2 cycles later all outputs are at reset values, and the next pixel (0,0) plus frame_start arrive 2 cycles after release.
